// File: rtl/cla_pkg.sv
// Shared defaults and types for the pipelined carry-lookahead adder.
// Result flags travel from stage S2 to the outputs as one bundle.
package cla_pkg;

  localparam int CLA_WIDTH = 16;
  localparam int CLA_GROUP = 4;
  localparam int NGROUPS   = CLA_WIDTH / CLA_GROUP;

  typedef struct packed {
    logic cout;
    logic ovf;
    logic blk_g;
    logic blk_p;
  } flags_t;

endpackage

// File: rtl/lookahead_carry_unit4.sv
// 4-bit lookahead carry unit: flat sum-of-products carries, no ripple.
// Used both per bit-group and once over the group generate/propagate.
module lookahead_carry_unit4 (
  input  logic [3:0] g,
  input  logic [3:0] p,
  input  logic       c0,
  output logic [4:1] c,
  output logic       grp_g,
  output logic       grp_p
);

  always_comb begin
    c[1] = g[0]
         | (p[0] & c0);
    c[2] = g[1]
         | (p[1] & g[0])
         | (p[1] & p[0] & c0);
    c[3] = g[2]
         | (p[2] & g[1])
         | (p[2] & p[1] & g[0])
         | (p[2] & p[1] & p[0] & c0);
    grp_g = g[3]
          | (p[3] & g[2])
          | (p[3] & p[2] & g[1])
          | (p[3] & p[2] & p[1] & g[0]);
    grp_p = &p;
    c[4] = grp_g | (grp_p & c0);
  end

endmodule

// File: rtl/cla_pipe_adder16.sv
// Two-stage valid/ready carry-lookahead adder: S1 holds g/p, S2 the result.
// Two lookahead levels: per-group units, then one unit over group G/P.
module cla_pipe_adder16
  import cla_pkg::*;
#(
  parameter int WIDTH = CLA_WIDTH,
  parameter int GROUP = CLA_GROUP
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             blk_g,
  output logic             blk_p
);

  localparam int NG = WIDTH / GROUP;

  logic             s1_v_q, s1_v_d;
  logic [WIDTH-1:0] g_q, g_d;
  logic [WIDTH-1:0] p_q, p_d;
  logic             cin_q, cin_d;
  logic             s2_v_q, s2_v_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  flags_t           flags_q, flags_d;

  logic             s1_adv, s2_adv, in_fire;
  logic [3:0]       gg, gp;
  logic [4:1]       bc;
  logic             blk_g_c, blk_p_c;
  logic [WIDTH-1:0] bit_c;
  logic [NG-1:0]    unused_c4;

  lookahead_carry_unit4 u_blk (
    .g     (gg),
    .p     (gp),
    .c0    (cin_q),
    .c     (bc),
    .grp_g (blk_g_c),
    .grp_p (blk_p_c)
  );

  // Unused group slots propagate, so bc[4] is always the carry out.
  for (genvar k = 0; k < 4; k++) begin : g_grp
    if (k < NG) begin : g_on
      logic       gc0;
      logic [4:1] gc;
      if (k == 0) begin : g_c0
        assign gc0 = cin_q;
      end else begin : g_ck
        assign gc0 = bc[k];
      end
      lookahead_carry_unit4 u_grp (
        .g     (g_q[4*k +: 4]),
        .p     (p_q[4*k +: 4]),
        .c0    (gc0),
        .c     (gc),
        .grp_g (gg[k]),
        .grp_p (gp[k])
      );
      assign bit_c[4*k +: 4] = {gc[3:1], gc0};
      assign unused_c4[k]    = gc[4];
    end else begin : g_pad
      assign gg[k] = 1'b0;
      assign gp[k] = 1'b1;
    end
  end

  always_comb begin
    s2_adv   = !s2_v_q || out_ready;
    s1_adv   = !s1_v_q || s2_adv;
    in_ready = !rst && s1_adv;
    in_fire  = in_valid && in_ready;

    s1_v_d  = s1_v_q;
    g_d     = g_q;
    p_d     = p_q;
    cin_d   = cin_q;
    s2_v_d  = s2_v_q;
    sum_d   = sum_q;
    flags_d = flags_q;

    if (s1_adv) begin
      s1_v_d = in_fire;
    end
    if (in_fire) begin
      g_d   = a & b;
      p_d   = a ^ b;
      cin_d = cin;
    end
    if (s2_adv) begin
      s2_v_d = s1_v_q;
      if (s1_v_q) begin
        sum_d         = p_q ^ bit_c;
        flags_d.cout  = bc[4];
        flags_d.ovf   = bit_c[WIDTH-1] ^ bc[4];
        flags_d.blk_g = blk_g_c;
        flags_d.blk_p = blk_p_c;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v_q  <= 1'b0;
      g_q     <= '0;
      p_q     <= '0;
      cin_q   <= 1'b0;
      s2_v_q  <= 1'b0;
      sum_q   <= '0;
      flags_q <= '0;
    end else begin
      s1_v_q  <= s1_v_d;
      g_q     <= g_d;
      p_q     <= p_d;
      cin_q   <= cin_d;
      s2_v_q  <= s2_v_d;
      sum_q   <= sum_d;
      flags_q <= flags_d;
    end
  end

  assign out_valid = s2_v_q;
  assign sum       = sum_q;
  assign cout      = flags_q.cout;
  assign ovf       = flags_q.ovf;
  assign blk_g     = flags_q.blk_g;
  assign blk_p     = flags_q.blk_p;

endmodule
